// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Each bit is decided by a 3-sample majority vote around the bit centre; break frames are flagged.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_t;

  state_t               state_q;
  logic                 sync1_q, sync2_q, prev_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 samp_a_q, samp_b_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q, pe_acc_q, fe_acc_q, zero_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, brk_q, busy_q;

  logic bit_mid, bit_end, maj;

  assign bit_mid = (cnt_q == CW'(HALF + 1));
  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign maj     = (samp_a_q & samp_b_q) | (samp_a_q & sync2_q) | (samp_b_q & sync2_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
      shift_q  <= '0;
      par_q    <= 1'b0;
      pe_acc_q <= 1'b0;
      fe_acc_q <= 1'b0;
      zero_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      if (state_q != S_IDLE && state_q != S_BRKWAIT)
        cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      if (cnt_q == CW'(HALF - 1)) samp_a_q <= sync2_q;
      if (cnt_q == CW'(HALF))     samp_b_q <= sync2_q;

      case (state_q)
        // The edge-detect cycle itself counts as bit count 0.
        S_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q  <= S_START;
            cnt_q    <= CW'(1);
            idx_q    <= '0;
            par_q    <= 1'b0;
            pe_acc_q <= 1'b0;
            fe_acc_q <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_mid && maj) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_mid) begin
            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            par_q   <= par_q ^ maj;
            if (maj) zero_q <= 1'b0;
          end
          if (bit_end) begin
            if (idx_q == IW'(DATA_BITS - 1)) begin
              idx_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_mid) begin
            pe_acc_q <= (PARITY == 1) ? ~(par_q ^ maj) : (par_q ^ maj);
            if (maj) zero_q <= 1'b0;
          end
          if (bit_end) state_q <= S_STOP;
        end
        // The last stop bit reports as soon as it is decided, not at the bit end.
        S_STOP: begin
          if (bit_mid) begin
            if (idx_q == IW'(STOP_BITS - 1)) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              perr_q  <= pe_acc_q;
              ferr_q  <= fe_acc_q | ~maj;
              cnt_q   <= '0;
              idx_q   <= '0;
              if (zero_q && !maj) begin
                brk_q   <= 1'b1;
                state_q <= S_BRKWAIT;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              fe_acc_q <= fe_acc_q | ~maj;
              if (maj) zero_q <= 1'b0;
            end
          end else if (bit_end) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_BRKWAIT: begin
          if (sync2_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 5N2) at 16 clk/bit, table-driven frames
// plus hand-written break, false-start, back-to-back and mid-frame reset sequences.
module tb_uart_rx_cfg;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic       v0, pe0, fe0, bk0, by0;
  logic       v1, pe1, fe1, bk1, by1;
  logic       v2, pe2, fe2, bk2, by2;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .n_reset(n_reset), .rx(rx0), .data(d0), .valid(v0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bk0), .busy(by0));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .n_reset(n_reset), .rx(rx1), .data(d1), .valid(v1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bk1), .busy(by1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .n_reset(n_reset), .rx(rx2), .data(d2), .valid(v2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bk2), .busy(by2));

  typedef struct packed {
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    logic        brk;
    logic [15:0] lat;
  } obs_t;

  typedef struct {
    int         inst;
    logic [8:0] word;
    logic       pbit;
    logic [1:0] stops;
    int         glitch;
    obs_t       exp;
  } vec_t;

  obs_t exp_q[$];
  obs_t got_q[$];
  int   start_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic obs_t mk_obs(input logic [8:0] dv, input logic pe, input logic fe,
                                  input logic bk, input int lat);
    obs_t o;
    o.data = dv; o.perr = pe; o.ferr = fe; o.brk = bk; o.lat = 16'(lat);
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int inst, input logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Called 1 time unit after a rising edge; that cycle is cycle 0 of the frame.
  task automatic drive_frame(input int inst, input logic [8:0] word, input logic pbit,
                             input logic [1:0] stops, input int glitch, input int last_len);
    logic bits[16];
    int   n, len, nb, ns;
    bit   hp;
    nb = (inst == 2) ? 5 : 8;
    ns = (inst == 2) ? 2 : 1;
    hp = (inst == 1);
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin bits[n] = word[i]; n++; end
    if (hp) begin bits[n] = pbit; n++; end
    for (int i = 0; i < ns; i++) begin bits[n] = stops[i]; n++; end
    start_q.push_back(cyc);
    for (int b = 0; b < n; b++) begin
      len = (b == n - 1) ? last_len : CPB;
      for (int c = 0; c < len; c++) begin
        set_line(inst, bits[b] ^ ((b == glitch && c == HALF) ? 1'b1 : 1'b0));
        @(posedge clk);
        #1;
      end
    end
    set_line(inst, 1'b1);
  endtask

  task automatic add_vec(input int inst, input logic [8:0] word, input logic pbit,
                         input logic [1:0] stops, input int glitch, input obs_t e);
    vec_t v;
    v.inst = inst; v.word = word; v.pbit = pbit; v.stops = stops; v.glitch = glitch; v.exp = e;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic capture(input logic [8:0] dv, input logic pe, input logic fe, input logic bk);
    obs_t o;
    o = mk_obs(dv, pe, fe, bk, 0);
    if (start_q.size() > 0) o.lat = 16'(cyc - start_q.pop_front());
    got_q.push_back(o);
  endtask

  always @(negedge clk) begin
    if (v0 || bk0) capture({1'b0, d0}, pe0, fe0, bk0);
    if (v1 || bk1) capture({1'b0, d1}, pe1, fe1, bk1);
    if (v2 || bk2) capture({4'b0, d2}, pe2, fe2, bk2);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    obs_t e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s missing_valid: got none required data 0x%0h", tag, e.data);
      end else begin
        g = got_q.pop_front();
        check({tag, " data"}, 32'(g.data), 32'(e.data));
        check({tag, " parity_err"}, 32'(g.perr), 32'(e.perr));
        check({tag, " frame_err"}, 32'(g.ferr), 32'(e.ferr));
        check({tag, " break_det"}, 32'(g.brk), 32'(e.brk));
        check({tag, " latency"}, 32'(g.lat), 32'(e.lat));
      end
    end
    check({tag, " extra_strobes"}, 32'(got_q.size()), 32'(0));
    got_q.delete();
    start_q.delete();
  endtask

  task automatic wait_busy_low(input string tag, input int limit);
    int k = 0;
    while (by0 && k < limit) begin
      tick(1);
      k++;
    end
    check(tag, 32'(by0), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    //        inst word    pbit stops  glitch        data   pe ferr brk lat
    add_vec(0, 9'hA5, 1'b0, 2'b01, -1, mk_obs(9'hA5, 0, 0, 0, 156));
    add_vec(0, 9'h3C, 1'b0, 2'b00, -1, mk_obs(9'h3C, 0, 1, 0, 156));
    add_vec(1, 9'h07, 1'b0, 2'b01, -1, mk_obs(9'h07, 1, 0, 0, 172));
    add_vec(1, 9'h07, 1'b1, 2'b01, -1, mk_obs(9'h07, 0, 0, 0, 172));
    add_vec(2, 9'h15, 1'b0, 2'b11, -1, mk_obs(9'h15, 0, 0, 0, 124));
    add_vec(0, 9'h00, 1'b0, 2'b01, -1, mk_obs(9'h00, 0, 0, 0, 156));
    add_vec(0, 9'hFF, 1'b0, 2'b01, -1, mk_obs(9'hFF, 0, 0, 0, 156));
    add_vec(1, 9'hFF, 1'b0, 2'b01, -1, mk_obs(9'hFF, 0, 0, 0, 172));
    add_vec(1, 9'h80, 1'b0, 2'b01, -1, mk_obs(9'h80, 1, 0, 0, 172));
    add_vec(2, 9'h0A, 1'b0, 2'b01, -1, mk_obs(9'h0A, 0, 1, 0, 124));
    add_vec(0, 9'hA4, 1'b0, 2'b01,  1, mk_obs(9'hA4, 0, 0, 0, 156));
    add_vec(0, 9'h5B, 1'b0, 2'b01,  0, mk_obs(9'h5B, 0, 0, 0, 156));
    add_vec(2, 9'h1F, 1'b0, 2'b11,  5, mk_obs(9'h1F, 0, 0, 0, 124));
    add_vec(1, 9'h00, 1'b0, 2'b00, -1, mk_obs(9'h00, 0, 1, 1, 172));

    n_reset = 1'b0;
    tick(3);
    check("reset data", 32'(d0), 32'(0));
    check("reset valid", 32'(v0), 32'(0));
    check("reset busy", 32'(by0), 32'(0));
    check("reset errors", 32'({pe0, fe0, bk0}), 32'(0));
    n_reset = 1'b1;
    tick(5);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp);
      drive_frame(vecs[i].inst, vecs[i].word, vecs[i].pbit, vecs[i].stops, vecs[i].glitch, CPB);
      tick(20);
      drain($sformatf("vec%0d", i));
    end

    // False start: 4-clk low pulse on an idle line.
    rx0 = 1'b0;
    tick(4);
    rx0 = 1'b1;
    check("false_start busy_rise", 32'(by0), 32'(1));
    wait_busy_low("false_start busy_drop", 11);
    tick(30);
    drain("false_start");

    // Break: line low for 12 bit times, then released.
    rx0 = 1'b0;
    start_q.push_back(cyc);
    tick(185);
    check("break busy_held", 32'(by0), 32'(1));
    tick(7);
    rx0 = 1'b1;
    wait_busy_low("break busy_drop", 6);
    tick(40);
    exp_q.push_back(mk_obs(9'h00, 0, 1, 1, 156));
    drain("break");

    // Back-to-back: second start edge arrives in the first idle cycle after valid.
    exp_q.push_back(mk_obs(9'h81, 0, 0, 0, 156));
    exp_q.push_back(mk_obs(9'h42, 0, 0, 0, 156));
    drive_frame(0, 9'h81, 1'b0, 2'b01, -1, 10);
    drive_frame(0, 9'h42, 1'b0, 2'b01, -1, CPB);
    tick(10);
    drain("back_to_back");

    // Reset in the middle of a 0xFF frame.
    rx0 = 1'b0;
    tick(16);
    rx0 = 1'b1;
    tick(40);
    check("midreset busy_before", 32'(by0), 32'(1));
    n_reset = 1'b0;
    #1;
    check("midreset data0", 32'(d0), 32'(0));
    check("midreset busy0", 32'(by0), 32'(0));
    check("midreset valid0", 32'(v0), 32'(0));
    check("midreset data2", 32'(d2), 32'(0));
    tick(3);
    n_reset = 1'b1;
    tick(20);
    drain("midreset_idle");

    exp_q.push_back(mk_obs(9'h5A, 0, 0, 0, 156));
    drive_frame(0, 9'h5A, 1'b0, 2'b01, -1, CPB);
    tick(10);
    drain("post_reset_8n1");

    exp_q.push_back(mk_obs(9'h15, 0, 0, 0, 124));
    drive_frame(2, 9'h15, 1'b0, 2'b11, -1, CPB);
    tick(10);
    drain("post_reset_5n2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
